// File: rtl/imm_ext_pkg.sv
// Shared encodings for the immediate extender: extension modes and
// skid-buffer occupancy states.
package imm_ext_pkg;

    localparam logic [1:0] MODE_SEXT_LONG  = 2'd0;
    localparam logic [1:0] MODE_SEXT_SHORT = 2'd1;
    localparam logic [1:0] MODE_ZEXT_LONG  = 2'd2;
    localparam logic [1:0] MODE_UPPER      = 2'd3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/imm_ext_skid.sv
// Generic 2-entry skid buffer. The output register is the head entry and
// the skid register catches one extra word so that in_ready depends only on
// occupancy, never combinationally on out_ready.
module imm_ext_skid
    import imm_ext_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_t      state, state_nx;
    logic [WIDTH-1:0] skid;
    logic             accept, consume;
    logic             load_out, load_skid, from_skid;

    // Handshake flags decode straight from the state register
    assign in_ready  = (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    // Occupancy state register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= ST_EMPTY;
        else       state <= state_nx;
    end

    // Next-state and datapath load selects
    always_comb begin
        state_nx  = state;
        load_out  = 1'b0;
        load_skid = 1'b0;
        from_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    load_out = 1'b1;
                    state_nx = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nx  = ST_TWO;
                end else if (consume) begin
                    state_nx = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (consume) begin
                    from_skid = 1'b1;
                    state_nx  = ST_ONE;
                end
            end
            default: state_nx = ST_EMPTY;
        endcase
    end

    // Head and skid data registers; head keeps its value when drained
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            skid     <= '0;
        end else begin
            if (load_out)       out_data <= in_data;
            else if (from_skid) out_data <= skid;
            if (load_skid)      skid     <= in_data;
        end
    end

endmodule

// File: rtl/imm_extend_unit.sv
// Handshaked immediate extender: sign/zero/upper extension with optional
// branch-offset shift, registered behind a 2-entry skid buffer.
module imm_extend_unit
    import imm_ext_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 16,
    parameter int SHORT_W = 10,
    parameter int LONG_W  = 12,
    parameter int UP_W    = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       mode,
    input  logic             shl1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    generate
        if (!(1 < SHORT_W && SHORT_W < LONG_W && LONG_W <= IN_W &&
              IN_W <= OUT_W && UP_W <= OUT_W)) begin : g_bad_params
            $error("imm_extend_unit: illegal width parameters");
        end
    endgenerate

    logic        [OUT_W-1:0] in_wide;
    logic signed [OUT_W-1:0] long_top, short_top;
    logic        [OUT_W-1:0] ext, ext_sh;

    assign in_wide = OUT_W'(in_data);

    // Extension by pushing the field to the top then shifting back down:
    // arithmetic shift replicates the field MSB, logical shift zero-fills.
    always_comb begin
        long_top  = in_wide << (OUT_W - LONG_W);
        short_top = in_wide << (OUT_W - SHORT_W);
        ext       = '0;
        case (mode)
            MODE_SEXT_LONG:  ext = long_top >>> (OUT_W - LONG_W);
            MODE_SEXT_SHORT: ext = short_top >>> (OUT_W - SHORT_W);
            MODE_ZEXT_LONG:  ext = long_top >> (OUT_W - LONG_W);
            MODE_UPPER:      ext = in_wide << (OUT_W - UP_W);
            default:         ext = '0;
        endcase
    end

    // Branch-offset shift; UPPER immediates are already positioned
    always_comb begin
        ext_sh = ext;
        if (shl1 && mode != MODE_UPPER) ext_sh = ext << 1;
    end

    imm_ext_skid #(.WIDTH(OUT_W)) u_skid (
        .CLK      (CLK),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (ext_sh),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

endmodule

// File: tb/tb_imm_extend_unit.sv
// Bench for imm_extend_unit: arithmetic reference model with a queue
// scoreboard checked every cycle, plus directed literal vectors.
module tb_imm_extend_unit;

    localparam int IN_W = 16, OUT_W = 16, SHORT_W = 10, LONG_W = 12, UP_W = 8;

    logic             CLK = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_data = '0;
    logic [1:0]       mode = 2'd0;
    logic             shl1 = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OUT_W-1:0] out_data;

    int nvec = 0, nerr = 0, cons_cnt = 0, cyc = 0;
    logic rst_flag = 1'b0, alt_en = 1'b0;
    logic [OUT_W-1:0] q[$];

    imm_extend_unit #(.IN_W(IN_W), .OUT_W(OUT_W), .SHORT_W(SHORT_W),
                      .LONG_W(LONG_W), .UP_W(UP_W)) dut (
        .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mode(mode), .shl1(shl1), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    // Reference: mask the field, OR in the sign by arithmetic, then shift
    function automatic logic [OUT_W-1:0] model(input logic [15:0] d, input logic [1:0] m,
                                               input logic s);
        longint full, fmask, v;
        int fw;
        full = (64'd1 << OUT_W) - 1;
        v = 0;
        if (m == 2'd3) begin
            v = ((longint'(d) & ((64'd1 << UP_W) - 1)) << (OUT_W - UP_W)) & full;
        end else begin
            fw    = (m == 2'd1) ? SHORT_W : LONG_W;
            fmask = (64'd1 << fw) - 1;
            v     = longint'(d) & fmask;
            if (m != 2'd2 && ((v >> (fw - 1)) & 1) == 1) v = v | (full & ~fmask);
            if (s) v = (v << 1) & full;
        end
        return OUT_W'(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge reset) rst_flag = 1'b1;
    always @(posedge CLK) cyc++;
    always @(posedge CLK) if (alt_en) #1 out_ready = ~out_ready;

    // Scoreboard compare: inputs are stable at negedge, so record the
    // handshakes that will fire on the coming posedge.
    always @(negedge CLK) begin
        if (rst_flag) begin
            q.delete();
            rst_flag = 1'b0;
        end
        if (!reset) begin
            chk("sb_out_valid", 32'(out_valid), 32'(q.size() > 0));
            if (q.size() > 0) chk("sb_out_data", 32'(out_data), 32'(q[0]));
            chk("sb_in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                cons_cnt++;
            end
            if (in_valid && in_ready) q.push_back(model(in_data, mode, shl1));
        end
    end

    task automatic drive(input logic [15:0] d, input logic [1:0] m, input logic s);
        in_valid = 1'b1;
        in_data  = d;
        mode     = m;
        shl1     = s;
    endtask

    // Returns at posedge+1 once the currently driven word has been taken
    task automatic wait_accept(input string name);
        logic ok;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            ok = in_ready;
            @(posedge CLK);
            #1;
            if (ok) return;
        end
        chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic send_chk(input string name, input logic [15:0] d, input logic [1:0] m,
                            input logic s, input logic [15:0] exp);
        @(posedge CLK);
        #1;
        drive(d, m, s);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_data"}, 32'(out_data), 32'(exp));
    endtask

    initial begin
        int t0;
        #2 reset = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge CLK);
        #1 reset = 1'b0;

        send_chk("m0_neg", 16'h0800, 2'd0, 1'b0, 16'hF800);
        send_chk("m0_pos", 16'h07FF, 2'd0, 1'b0, 16'h07FF);
        send_chk("m1_neg", 16'h0200, 2'd1, 1'b0, 16'hFE00);
        send_chk("m1_pos", 16'hFDFF, 2'd1, 1'b0, 16'h01FF);
        send_chk("m2_zext", 16'hFFFF, 2'd2, 1'b0, 16'h0FFF);
        send_chk("m3_upper", 16'h12A5, 2'd3, 1'b0, 16'hA500);
        send_chk("m0_shl1", 16'h0C00, 2'd0, 1'b1, 16'hF800);
        send_chk("m3_shl1", 16'h00A5, 2'd3, 1'b1, 16'hA500);
        send_chk("m2_shl1", 16'h0FFF, 2'd2, 1'b1, 16'h1FFE);

        // Backpressure: A, B fill the buffer, C stalls until drain
        @(posedge CLK);
        #1 out_ready = 1'b0;
        drive(16'h0800, 2'd0, 1'b0);
        @(posedge CLK);
        #1 drive(16'hFFFF, 2'd2, 1'b0);
        @(posedge CLK);
        #1 drive(16'h0200, 2'd1, 1'b0);
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        chk("bp_hold_a", 32'(out_data), 32'h0000F800);
        repeat (3) begin
            @(posedge CLK);
            #1;
            chk("bp_still_a", 32'(out_data), 32'h0000F800);
            chk("bp_still_full", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        chk("bp_out_a", 32'(out_data), 32'h0000F800);
        @(posedge CLK);
        #1;
        chk("bp_out_b_valid", 32'(out_valid), 32'd1);
        chk("bp_out_b", 32'(out_data), 32'h00000FFF);
        @(posedge CLK);
        #1 in_valid = 1'b0;
        chk("bp_out_c_valid", 32'(out_valid), 32'd1);
        chk("bp_out_c", 32'(out_data), 32'h0000FE00);
        @(posedge CLK);
        #1;

        // Alternating backpressure with continuous supply
        cons_cnt = 0;
        t0 = cyc;
        alt_en = 1'b1;
        for (int k = 0; k < 50; k++) begin
            drive(16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            wait_accept("alt");
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && cons_cnt < 50; i++) @(posedge CLK);
        alt_en = 1'b0;
        @(posedge CLK);
        #2 out_ready = 1'b1;
        chk("alt_count", 32'(cons_cnt), 32'd50);
        chk("alt_throughput", 32'((cyc - t0) <= 106), 32'd1);
        repeat (2) @(posedge CLK);

        // Reset while full, mid-cycle
        #1 out_ready = 1'b0;
        drive(16'h0123, 2'd0, 1'b0);
        wait_accept("rst_fill_a");
        drive(16'h0456, 2'd2, 1'b0);
        wait_accept("rst_fill_b");
        in_valid = 1'b0;
        chk("rst_pre_full", 32'(in_ready), 32'd0);
        #1 reset = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        drive(16'h12A5, 2'd3, 1'b0);
        @(posedge CLK);
        #1 in_valid = 1'b0;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_data", 32'(out_data), 32'h0000A500);
        repeat (3) @(posedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
